// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: walks a row-major feature map in 2x2 / stride-2 windows,
// streams each window into the maxpool unit as four consecutive samples,
// waits for the pooled result and writes it to the output RAM in
// row-major output order.
module maxpool_ctrl #(
  parameter int BITS       = 16,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int ADDR_W     = 6,
  parameter int OUT_ADDR_W = 4
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [BITS-1:0]       rd_data,
  output logic                  pool_start,
  output logic [BITS-1:0]       pool_data,
  input  logic                  pool_ready,
  input  logic [BITS-1:0]       pool_result,
  output logic                  wr_en,
  output logic [OUT_ADDR_W-1:0] wr_addr,
  output logic [BITS-1:0]       wr_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD0   = 3'd1,
    S_RD1   = 3'd2,
    S_RD2   = 3'd3,
    S_RD3   = 3'd4,
    S_LAST  = 3'd5,
    S_WAIT  = 3'd6,
    S_WRITE = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0]     ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]     IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]     OX_MAX   = ADDR_W'(IMG_W / 2 - 1);
  localparam logic [ADDR_W-1:0]     OY_MAX   = ADDR_W'(IMG_H / 2 - 1);
  localparam logic [OUT_ADDR_W-1:0] HALF_W_O = OUT_ADDR_W'(IMG_W / 2);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       ox_q, ox_d;
  logic [ADDR_W-1:0]       oy_q, oy_d;
  logic [OUT_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BITS-1:0]         wr_data_q, wr_data_d;
  logic                    done_q, done_d;

  logic [ADDR_W-1:0]       base_addr;
  logic [OUT_ADDR_W-1:0]   out_addr;
  logic                    last_win;

  // Window geometry: top-left read address, output slot and last-window flag.
  always_comb begin
    base_addr = ((oy_q << 1) * IMG_W_A) + (ox_q << 1);
    out_addr  = (OUT_ADDR_W'(oy_q) * HALF_W_O) + OUT_ADDR_W'(ox_q);
    last_win  = (ox_q == OX_MAX) && (oy_q == OY_MAX);
  end

  // Next-state logic, counter updates and strobes decoded from the current state.
  always_comb begin
    state_d    = state_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    pool_start = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          ox_d    = '0;
          oy_d    = '0;
          state_d = S_RD0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD0: begin
        rd_en   = 1'b1;
        rd_addr = base_addr;
        state_d = S_RD1;
      end
      S_RD1: begin
        // The RD0 word is on rd_data now, so the pooling unit starts here.
        rd_en      = 1'b1;
        rd_addr    = base_addr + ONE_A;
        pool_start = 1'b1;
        state_d    = S_RD2;
      end
      S_RD2: begin
        rd_en   = 1'b1;
        rd_addr = base_addr + IMG_W_A;
        state_d = S_RD3;
      end
      S_RD3: begin
        rd_en   = 1'b1;
        rd_addr = base_addr + IMG_W_A + ONE_A;
        state_d = S_LAST;
      end
      S_LAST: begin
        // Fourth sample is on pool_data; no read this cycle.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ready from the previous window was cleared during RD1, so this one is fresh.
        if (pool_ready) begin
          wr_data_d = pool_result;
          wr_addr_d = out_addr;
          state_d   = S_WRITE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (last_win) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (ox_q == OX_MAX) begin
          ox_d    = '0;
          oy_d    = oy_q + ONE_A;
          state_d = S_RD0;
        end else begin
          ox_d    = ox_q + ONE_A;
          state_d = S_RD0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, window counters and write-port registers; reset returns everything to idle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ox_q      <= '0;
      oy_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign pool_data = rd_data;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb_maxpool_ctrl: drives maxpool_ctrl with an input RAM model and a
// behavioural 2x2 maxpool unit, logs output-RAM writes and checks them
// against hand-computed window maxima and cycle timings.
module tb_maxpool_ctrl;

  localparam int BITS       = 16;
  localparam int IMG_W      = 8;
  localparam int IMG_H      = 8;
  localparam int ADDR_W     = 6;
  localparam int OUT_ADDR_W = 4;
  localparam int NWIN       = 16;
  localparam int SCAN_CYC   = 113;

  logic                  clk_in = 1'b0;
  logic                  rst    = 1'b1;
  logic                  go     = 1'b0;
  logic                  busy, done, rd_en, pool_start, wr_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [BITS-1:0]       rd_data;
  logic [BITS-1:0]       pool_data;
  logic [OUT_ADDR_W-1:0] wr_addr;
  logic [BITS-1:0]       wr_data;

  logic                  mp_ready;
  logic [BITS-1:0]       mp_res, mp_max, mp_fin;
  int                    mp_cnt, mp_wait;

  logic [BITS-1:0]       mem [64];
  logic [BITS-1:0]       expv [NWIN];
  int                    wr_a_q[$], wr_d_q[$], wr_c_q[$], ps_c_q[$];
  int                    cyc = 0;
  int                    rd_cnt = 0;
  int                    stall_abs = -1;
  int                    stall_len = 10;
  int                    n_checks = 0;
  int                    n_fail = 0;

  typedef struct packed {
    logic [15:0] v0;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] v3;
    logic [15:0] ex;
  } vec_t;
  vec_t tab [NWIN];

  maxpool_ctrl #(
    .BITS(BITS), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .OUT_ADDR_W(OUT_ADDR_W)
  ) dut (
    .clk_in(clk_in), .rst(rst), .go(go), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_start(pool_start), .pool_data(pool_data),
    .pool_ready(mp_ready), .pool_result(mp_res),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk_in = ~clk_in;

  // Cycle counter.
  always @(posedge clk_in) cyc <= cyc + 1;

  // Input RAM, one cycle read latency.
  always @(posedge clk_in) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  assign mp_fin = (pool_data > mp_max) ? pool_data : mp_max;

  // Maxpool unit model: four samples from start, ready after the fourth (plus optional stall).
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mp_ready <= 1'b0; mp_res <= '0; mp_max <= '0; mp_cnt <= 0; mp_wait <= 0;
    end else if (pool_start) begin
      mp_ready <= 1'b0; mp_max <= pool_data; mp_cnt <= 1;
    end else if (mp_cnt == 1 || mp_cnt == 2) begin
      mp_max <= mp_fin; mp_cnt <= mp_cnt + 1;
    end else if (mp_cnt == 3) begin
      if (wr_a_q.size() == stall_abs) begin
        mp_max <= mp_fin; mp_wait <= stall_len; mp_cnt <= 4;
      end else begin
        mp_res <= mp_fin; mp_ready <= 1'b1; mp_cnt <= 0;
      end
    end else if (mp_cnt == 4) begin
      if (mp_wait == 1) begin
        mp_res <= mp_max; mp_ready <= 1'b1; mp_cnt <= 0;
      end else begin
        mp_wait <= mp_wait - 1;
      end
    end
  end

  // Output-side monitor, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (wr_en) begin
      wr_a_q.push_back(int'(wr_addr));
      wr_d_q.push_back(int'(wr_data));
      wr_c_q.push_back(cyc);
    end
    if (pool_start) ps_c_q.push_back(cyc);
    if (rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic start_scan(output int g);
    @(negedge clk_in);
    go = 1'b1;
    g  = cyc;
    @(negedge clk_in);
    go = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, output int dl);
    dl = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (done) begin
        dl = cyc - g;
        break;
      end
    end
    if (dl < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic check_writes(input string tag, input int wb);
    chk({tag, "_nwrites"}, wr_a_q.size() - wb, NWIN);
    for (int i = 0; i < NWIN; i++) begin
      if (wb + i < wr_a_q.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), wr_a_q[wb + i], i);
        chk($sformatf("%s_data%0d", tag, i), wr_d_q[wb + i], int'(expv[i]));
      end
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},       int'(busy), 0);
    chk({tag, "_done"},       int'(done), 0);
    chk({tag, "_rd_en"},      int'(rd_en), 0);
    chk({tag, "_rd_addr"},    int'(rd_addr), 0);
    chk({tag, "_pool_start"}, int'(pool_start), 0);
    chk({tag, "_wr_en"},      int'(wr_en), 0);
    chk({tag, "_wr_addr"},    int'(wr_addr), 0);
    chk({tag, "_wr_data"},    int'(wr_data), 0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) mem[i] = 16'(i);
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++)
        expv[oy * 4 + ox] = 16'((2 * oy + 1) * IMG_W + 2 * ox + 1);
  endtask

  initial begin
    int g, g2, dl, wb, pb, rb, b;
    logic [15:0] m;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Ramp map 0..63: each window max is its bottom-right word
    load_ramp();
    wb = wr_a_q.size(); pb = ps_c_q.size(); rb = rd_cnt;
    start_scan(g);
    chk("ramp_busy_rd0", int'(busy), 1);
    chk("ramp_rd0_en", int'(rd_en), 1);
    chk("ramp_rd0_addr", int'(rd_addr), 0);
    @(negedge clk_in);
    chk("ramp_rd1_addr", int'(rd_addr), 1);
    @(negedge clk_in);
    chk("ramp_rd2_addr", int'(rd_addr), IMG_W);
    @(negedge clk_in);
    chk("ramp_rd3_addr", int'(rd_addr), IMG_W + 1);
    wait_done(g, 300, dl);
    chk("ramp_done_lat", dl, SCAN_CYC);
    chk("ramp_busy_at_done", int'(busy), 0);
    check_writes("ramp", wb);
    if (ps_c_q.size() > pb) chk("ramp_pool_start_lat", ps_c_q[pb] - g, 2);
    if (wr_c_q.size() > wb) chk("ramp_first_wr_lat", wr_c_q[wb] - g, 7);
    chk("ramp_reads", rd_cnt - rb, 64);

    // Table of window patterns, one per window; go held 3 cycles and pulsed while busy
    tab[0]  = {16'h8000, 16'h0001, 16'h0002, 16'h0003, 16'h8000};
    tab[1]  = {16'h0001, 16'h8000, 16'h0002, 16'h0003, 16'h8000};
    tab[2]  = {16'h0001, 16'h0002, 16'h8000, 16'h0003, 16'h8000};
    tab[3]  = {16'h0001, 16'h0002, 16'h0003, 16'h8000, 16'h8000};
    tab[4]  = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tab[5]  = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    tab[6]  = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    tab[7]  = {16'h7FFF, 16'h8000, 16'h7FFE, 16'h0001, 16'h8000};
    tab[8]  = {16'h1234, 16'h1235, 16'h1233, 16'h0000, 16'h1235};
    tab[9]  = {16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005};
    tab[10] = {16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0001};
    tab[11] = {16'hABCD, 16'hABCE, 16'hABCC, 16'h0000, 16'hABCE};
    tab[12] = {16'h00FF, 16'hFF00, 16'h0F0F, 16'hF0F0, 16'hFF00};
    tab[13] = {16'h8001, 16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFFE};
    tab[14] = {16'h0100, 16'h0010, 16'h0001, 16'h1000, 16'h1000};
    tab[15] = {16'hFFFE, 16'hFFFF, 16'hFFFD, 16'hFFFC, 16'hFFFF};
    for (int k = 0; k < NWIN; k++) begin
      b = 2 * (k / 4) * IMG_W + 2 * (k % 4);
      mem[b]             = tab[k].v0;
      mem[b + 1]         = tab[k].v1;
      mem[b + IMG_W]     = tab[k].v2;
      mem[b + IMG_W + 1] = tab[k].v3;
      expv[k]            = tab[k].ex;
    end
    wb = wr_a_q.size();
    @(negedge clk_in);
    go = 1'b1;
    g  = cyc;
    repeat (3) @(negedge clk_in);
    go = 1'b0;
    repeat (47) @(negedge clk_in);
    go = 1'b1;
    @(negedge clk_in);
    go = 1'b0;
    wait_done(g, 300, dl);
    chk("tab_done_lat", dl, SCAN_CYC);
    check_writes("tab", wb);
    repeat (30) @(negedge clk_in);
    chk("tab_single_scan", wr_a_q.size() - wb, NWIN);
    chk("tab_idle_after", int'(busy), 0);

    // Random map with 0xFFFF / 0x0000 windows, 10-cycle ready stall in window 3
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom_range(0, 65535));
    mem[0] = 16'hFFFF;
    mem[2] = 16'h0000; mem[3] = 16'h0000; mem[10] = 16'h0000; mem[11] = 16'h0000;
    for (int k = 0; k < NWIN; k++) begin
      b = 2 * (k / 4) * IMG_W + 2 * (k % 4);
      m = mem[b];
      if (mem[b + 1] > m) m = mem[b + 1];
      if (mem[b + IMG_W] > m) m = mem[b + IMG_W];
      if (mem[b + IMG_W + 1] > m) m = mem[b + IMG_W + 1];
      expv[k] = m;
    end
    wb = wr_a_q.size(); rb = rd_cnt;
    stall_abs = wb + 3;
    start_scan(g);
    wait_done(g, 400, dl);
    stall_abs = -1;
    chk("rand_done_lat", dl, SCAN_CYC + 10);
    check_writes("rand", wb);
    if (wr_a_q.size() >= wb + 4) begin
      chk("rand_stall_gap", wr_c_q[wb + 3] - wr_c_q[wb + 2], 17);
      chk("rand_normal_gap", wr_c_q[wb + 2] - wr_c_q[wb + 1], 7);
    end
    chk("rand_reads", rd_cnt - rb, 64);

    // go coincident with done starts a second scan immediately
    wb = wr_a_q.size();
    start_scan(g);
    wait_done(g, 300, dl);
    chk("back_first_lat", dl, SCAN_CYC);
    go = 1'b1;
    g2 = cyc;
    @(negedge clk_in);
    go = 1'b0;
    chk("back_busy_next", int'(busy), 1);
    wait_done(g2, 300, dl);
    chk("back_second_lat", dl, SCAN_CYC);
    check_writes("back2", wb + NWIN);

    // Reset asserted in WAIT of window 5
    load_ramp();
    wb = wr_a_q.size();
    start_scan(g);
    repeat (40) @(negedge clk_in);
    chk("rst_pre_wait_busy", int'(busy), 1);
    chk("rst_pre_wait_rd_en", int'(rd_en), 0);
    #1 rst = 1'b1;
    #1 chk_idle_outputs("midrst");
    rb = rd_cnt;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("midrst_writes", wr_a_q.size() - wb, 5);
    chk("midrst_reads", rd_cnt - rb, 0);
    chk("midrst_idle", int'(busy), 0);

    // Full scan after reset release
    wb = wr_a_q.size();
    start_scan(g);
    wait_done(g, 300, dl);
    chk("post_rst_lat", dl, SCAN_CYC);
    check_writes("post_rst", wb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_ctrl.md
# maxpool_ctrl

Sequencer for the 2x2 / stride-2 `maxpool` datapath unit (BITS=16, pool_size=4). On a `go` pulse it scans a feature map stored row-major in a 1-cycle-latency read RAM and feeds each 2x2 window to `maxpool` as four consecutive samples. It waits for the unit's `ready`, then writes each pooled result to an output RAM in row-major output order. It sits between the conv-layer output buffer and the next layer's input buffer.

## Interface
- `BITS`, 16, data width; must equal `maxpool` `bits`
- `IMG_W`, 8, input map width; even, ≥2
- `IMG_H`, 8, input map height; even, ≥2
- `ADDR_W`, 6, read address width; ≥ clog2(IMG_W*IMG_H)
- `OUT_ADDR_W`, 4, write address width; ≥ clog2(IMG_W*IMG_H/4)
- `clk_in`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `go`  in  1  start pulse; sampled only in IDLE
- `busy`  out  1  high from the cycle after `go` is accepted until the last write completes
- `done`  out  1  one-cycle pulse after the last write
- `rd_en`  out  1  read strobe to the input RAM
- `rd_addr`  out  ADDR_W  read address
- `rd_data`  in  BITS  RAM data, valid the cycle after `rd_en`
- `pool_start`  out  1  to `maxpool.start`
- `pool_data`  out  BITS  to `maxpool.data_in`; combinational copy of `rd_data`
- `pool_ready`  in  1  from `maxpool.ready`
- `pool_result`  in  BITS  from `maxpool.data_out`
- `wr_en`  out  1  write strobe to the output RAM
- `wr_addr`  out  OUT_ADDR_W  write address
- `wr_data`  out  BITS  pooled value

## Operation
- States: IDLE, RD0, RD1, RD2, RD3, LAST, WAIT, WRITE.
- Window counters: `oy` runs 0..IMG_H/2-1 (outer loop) and `ox` runs 0..IMG_W/2-1 (inner loop). Base address is `b = 2*oy*IMG_W + 2*ox`.
- IDLE: when `go`=1, load `ox`=`oy`=0 and go to RD0.
- RD0..RD3: `rd_en`=1. `rd_addr` = b, b+1, b+IMG_W, b+IMG_W+1 respectively.
- `pool_start`=1 only in RD1, the cycle in which the RD0 word is on `rd_data`. The words read in RD0..RD3 appear on `pool_data` during RD1, RD2, RD3 and LAST.
- LAST: `rd_en`=0. Go to WAIT.
- WAIT: hold until `pool_ready`=1. In that cycle, register `wr_data` <= `pool_result` and `wr_addr` <= `oy*(IMG_W/2)+ox`, then go to WRITE. `pool_ready` is ignored in every other state.
- WRITE: `wr_en`=1 for exactly this cycle.
  - If the window just written is not the last, advance `ox` (wrapping to 0 and incrementing `oy`) and go to RD0.
  - After the last window, go to IDLE and assert `done` for one cycle.
- `go` while `busy` is ignored. `go` in the same cycle as `done` is accepted.
- All address arithmetic is unsigned. Products are computed at ADDR_W / OUT_ADDR_W width; no wrap occurs within legal parameters.
- Reset mid-operation: all state clears asynchronously and the block returns to IDLE. No further reads or writes are issued. `maxpool` must be reset at the same time; the top level ties its `rst_n` to `~rst`.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `pool_start`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0. State is IDLE.
- With `go` at cycle g: RD0 is at g+1, `pool_start` at g+2, and LAST at g+5.
- `maxpool` raises `ready` at g+6. WAIT sees it at g+6, and WRITE (`wr_en`) follows at g+7.
- Steady-state cost is 7 cycles per window. Total from `go` to `done` is 1 + 7·(IMG_W·IMG_H/4) cycles; for 8x8 that is 113.
- `pool_ready` stays high from the previous window until `maxpool` clears it at the end of RD1. WAIT is entered only after this point, so a stale ready cannot be captured.
- If `pool_ready` never rises, WAIT holds indefinitely with `busy`=1. Only `rst` exits this condition.

## Test plan
- 4x4 map holding values 0..15 row-major, `go` pulse → writes (addr,data) = (0,5), (1,7), (2,13), (3,15); `done` is 29 cycles after `go`.
- 8x8 map with random 16-bit unsigned values, including 0xFFFF and 0x0000 → 16 writes, each equal to its window max, with `wr_addr` 0..15 in order.
- Window maximum in each of the four positions, e.g. {0x8000,1,2,3}, {1,0x8000,2,3}, … → 0x8000 every time. An all-zero window → 0.
- `go` pulsed during `busy`, and `go` held high for 3 cycles → a single scan only. `go` asserted coincident with `done` → a second scan starts immediately.
- `rst` asserted in WAIT of window 5 → all outputs at reset values the same cycle, no `wr_en`. A new `go` after release → a full correct scan.
- `pool_ready` forced low for 10 extra cycles in one window → `wr_en` delayed by exactly 10 cycles, data still correct, no extra reads.
